frame_scanout: RTL and testbench

- Downstream consumer of the ray tracer's rendered frame.
- Once the tracer's interrupt is serviced, software pulses start. The block then reads the width*height pixel words at frameAddress over a simple in-order read port.
- Pixels are buffered in an internal FIFO and presented as a valid/ready raster stream, with line and frame markers, for the display/compositor stage.
- Credit-based issue ensures the FIFO never overflows.

---
 rtl/scanout_pkg.sv | 18 +
 rtl/scan_fifo.sv | 54 +++++
 rtl/frame_scanout.sv | 160 ++++++++++++++++
 tb/tb_frame_scanout.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scanout_pkg.sv
// Shared types for the frame scanout block: FSM states and the pixel and
// dimension word types used on the tracer-to-display path.
package scanout_pkg;

    localparam int PIXEL_WIDTH = 24;
    localparam int DIM_WIDTH   = 12;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FINISH
    } state_e;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;
    typedef logic [DIM_WIDTH-1:0]   dim_t;

endpackage

// File: rtl/scan_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on head_o while
// the FIFO is non-empty. Push and pop may be asserted together at any fill level.
module scan_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         head_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          empty_o,
    output logic                          full_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO can still take a push in the same cycle it pops.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the count guards every read.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/frame_scanout.sv
// Reads a width*height frame from memory with credit-limited in-order requests
// and streams it out as valid/ready pixels with line and frame markers.
module frame_scanout
    import scanout_pkg::*;
#(
    parameter int DATA_WIDTH    = 24,
    parameter int ADDRESS_WIDTH = 32,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] frameAddress,
    input  logic [11:0]              width,
    input  logic [11:0]              height,
    output logic                     busy,
    output logic                     done,
    output logic                     reqValid,
    input  logic                     reqReady,
    output logic [ADDRESS_WIDTH-1:0] reqAddress,
    input  logic                     respValid,
    input  logic [DATA_WIDTH-1:0]    respData,
    output logic                     pixelValid,
    input  logic                     pixelReady,
    output logic [DATA_WIDTH-1:0]    pixelData,
    output logic                     pixelLast,
    output logic                     pixelEnd
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    state_e                   state_q;
    dim_t                     width_q, height_q;
    dim_t                     req_x_q, req_y_q;
    dim_t                     out_x_q, out_y_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]         outstanding_q, outstanding_d;
    logic [CNT_W-1:0]         fifo_count, fifo_count_d;
    logic [SUM_W-1:0]         credit_sum;
    logic                     req_valid_q, busy_q, done_q;
    logic                     req_hs, resp_accept, pop, req_last, credit_ok;
    logic                     fifo_empty, fifo_full;

    scan_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (resp_accept),
        .push_data_i (respData),
        .pop_i       (pop),
        .head_o      (pixelData),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign reqValid   = req_valid_q;
    assign reqAddress = addr_q;
    assign pixelValid = ~fifo_empty;
    assign pixelLast  = pixelValid & (out_x_q == width_q - dim_t'(1));
    assign pixelEnd   = pixelLast & (out_y_q == height_q - dim_t'(1));

    // Credit is judged on next-cycle occupancy so a request issued now can
    // never land in a FIFO that is already spoken for.
    always_comb begin
        req_hs        = req_valid_q & reqReady;
        resp_accept   = respValid & (outstanding_q != '0);
        pop           = pixelValid & pixelReady;
        outstanding_d = outstanding_q + CNT_W'(req_hs) - CNT_W'(resp_accept);
        fifo_count_d  = fifo_count + CNT_W'(resp_accept) - CNT_W'(pop);
        credit_sum    = {1'b0, outstanding_d} + {1'b0, fifo_count_d};
        credit_ok     = ~fifo_full & (credit_sum < SUM_W'(FIFO_DEPTH));
        req_last      = (req_x_q == width_q - dim_t'(1)) &&
                        (req_y_q == height_q - dim_t'(1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            width_q       <= '0;
            height_q      <= '0;
            req_x_q       <= '0;
            req_y_q       <= '0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            addr_q        <= '0;
            outstanding_q <= '0;
            req_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            done_q        <= 1'b0;

            if (pop) begin
                if (pixelLast) begin
                    out_x_q <= '0;
                    out_y_q <= out_y_q + dim_t'(1);
                end else begin
                    out_x_q <= out_x_q + dim_t'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        width_q  <= width;
                        height_q <= height;
                        addr_q   <= frameAddress;
                        req_x_q  <= '0;
                        req_y_q  <= '0;
                        out_x_q  <= '0;
                        out_y_q  <= '0;
                        busy_q   <= 1'b1;
                        if (width == '0 || height == '0) begin
                            state_q <= FINISH;
                        end else begin
                            state_q     <= FETCH;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (req_hs) begin
                        addr_q <= addr_q + ADDRESS_WIDTH'(1);
                        if (req_x_q == width_q - dim_t'(1)) begin
                            req_x_q <= '0;
                            req_y_q <= req_y_q + dim_t'(1);
                        end else begin
                            req_x_q <= req_x_q + dim_t'(1);
                        end
                        if (req_last) begin
                            req_valid_q <= 1'b0;
                            state_q     <= DRAIN;
                        end else begin
                            req_valid_q <= credit_ok;
                        end
                    end else if (!req_valid_q) begin
                        req_valid_q <= credit_ok;
                    end
                end
                DRAIN: begin
                    if (pop && pixelEnd) state_q <= FINISH;
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout: a memory model with programmable latency
// and request stalls, plus a pixel consumer with programmable backpressure.
module tb_frame_scanout;

    localparam int DW = 24;
    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset, start;
    logic [AW-1:0] frameAddress;
    logic [11:0]   width, height;
    logic          busy, done, reqValid, reqReady, respValid;
    logic [AW-1:0] reqAddress;
    logic [DW-1:0] respData, pixelData;
    logic          pixelValid, pixelReady, pixelLast, pixelEnd;

    frame_scanout dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .frameAddress (frameAddress),
        .width        (width),
        .height       (height),
        .busy         (busy),
        .done         (done),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqAddress   (reqAddress),
        .respValid    (respValid),
        .respData     (respData),
        .pixelValid   (pixelValid),
        .pixelReady   (pixelReady),
        .pixelData    (pixelData),
        .pixelLast    (pixelLast),
        .pixelEnd     (pixelEnd)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          fend;
    } pix_t;

    int checks   = 0;
    int failures = 0;

    int resp_delay = 1;
    int rr_mode    = 0;  // 0: reqReady always high, 1: random
    int pr_mode    = 1;  // 0: pixelReady low, 1: high, 2: random
    int cyc        = 0;

    pend_t         pend_q[$];
    logic [AW-1:0] req_log[$];
    pix_t          pix_log[$];

    int done_cnt, done_busy_err, stall_err, hold_err;
    int inflight, max_inflight, resp_cnt, pv_cnt;

    logic          prev_req_stall, prev_pix_stall;
    logic [AW-1:0] prev_req_addr;
    logic [DW-1:0] prev_pix_data;
    logic          prev_last, prev_end;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 24'h5AC396;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory and consumer drivers: inputs change 1 time unit after each edge.
    initial begin
        reqReady   = 1'b0;
        respValid  = 1'b0;
        respData   = '0;
        pixelReady = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                respValid = 1'b1;
                respData  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                respValid = 1'b0;
                respData  = '0;
            end
            reqReady   = (rr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            pixelReady = (pr_mode == 2) ? 1'($urandom_range(0, 1)) : (pr_mode == 1);
        end
    end

    // Monitor: records handshakes that the next rising edge will take.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                inflight       = 0;
                prev_req_stall = 1'b0;
                prev_pix_stall = 1'b0;
            end else begin
                if (prev_req_stall && (!reqValid || reqAddress !== prev_req_addr)) stall_err++;
                prev_req_stall = reqValid && !reqReady;
                prev_req_addr  = reqAddress;
                if (reqValid && reqReady) begin
                    req_log.push_back(reqAddress);
                    pend_q.push_back('{reqAddress, cyc + resp_delay});
                    inflight++;
                end
                if (prev_pix_stall && (!pixelValid || pixelData !== prev_pix_data ||
                    pixelLast !== prev_last || pixelEnd !== prev_end)) hold_err++;
                prev_pix_stall = pixelValid && !pixelReady;
                prev_pix_data  = pixelData;
                prev_last      = pixelLast;
                prev_end       = pixelEnd;
                if (pixelValid && pixelReady) begin
                    pix_log.push_back('{pixelData, pixelLast, pixelEnd});
                    inflight--;
                end
                if (pixelValid) pv_cnt++;
                if (respValid) resp_cnt++;
                if (done) begin
                    done_cnt++;
                    if (busy) done_busy_err++;
                end
                if (inflight > max_inflight) max_inflight = inflight;
            end
        end
    end

    task automatic clear_logs();
        req_log.delete();
        pix_log.delete();
        done_cnt      = 0;
        done_busy_err = 0;
        stall_err     = 0;
        hold_err      = 0;
        max_inflight  = 0;
        resp_cnt      = 0;
        pv_cnt        = 0;
    endtask

    task automatic start_frame(input logic [AW-1:0] base, input int w, input int h);
        @(posedge clock);
        #1;
        clear_logs();
        start        = 1'b1;
        frameAddress = base;
        width        = 12'(w);
        height       = 12'(h);
        @(posedge clock);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("reqvalid_after_start", reqValid, (w != 0 && h != 0));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("done_within_budget", (done_cnt != 0), 1);
        repeat (4) @(negedge clock);
    endtask

    task automatic check_frame(input string tag, input logic [AW-1:0] base, input int w, input int h);
        int n = w * h;
        logic [AW-1:0] a;
        check($sformatf("%s_req_count", tag), req_log.size(), n);
        check($sformatf("%s_pix_count", tag), pix_log.size(), n);
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            if (i < req_log.size())
                check($sformatf("%s_addr%0d", tag, i), req_log[i], a);
            if (i < pix_log.size()) begin
                check($sformatf("%s_data%0d", tag, i), pix_log[i].data, mem_word(a));
                check($sformatf("%s_last%0d", tag, i), pix_log[i].last, (i % w == w - 1));
                check($sformatf("%s_end%0d", tag, i), pix_log[i].fend, (i == n - 1));
            end
        end
        check($sformatf("%s_done_count", tag), done_cnt, 1);
        check($sformatf("%s_done_busy", tag), done_busy_err, 0);
        check($sformatf("%s_req_stable", tag), stall_err, 0);
        check($sformatf("%s_pix_hold", tag), hold_err, 0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        frameAddress = '0;
        width        = '0;
        height       = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_reqvalid", reqValid, 0);
        check("rst_reqaddr", reqAddress, 0);
        check("rst_pixvalid", pixelValid, 0);
        check("rst_pixlast", pixelLast, 0);
        check("rst_pixend", pixelEnd, 0);
        reset = 1'b0;

        // 4x2 frame, 1-cycle memory, consumer always ready.
        start_frame(32'h1000, 4, 2);
        wait_done(200);
        check_frame("f4x2", 32'h1000, 4, 2);
        check("f4x2_idle_busy", busy, 0);

        // 64x1 frame with the consumer stalled: credit must cap at the depth.
        pr_mode = 0;
        start_frame(32'h2000, 64, 1);
        repeat (200) @(negedge clock);
        check("stall_max_inflight", max_inflight, 16);
        check("stall_req_count", req_log.size(), 16);
        check("stall_pix_count", pix_log.size(), 0);
        check("stall_pixvalid", pixelValid, 1);
        check("stall_head", pixelData, mem_word(32'h2000));
        pr_mode = 1;
        wait_done(1000);
        check_frame("f64x1", 32'h2000, 64, 1);
        check("f64x1_max_inflight", max_inflight, 16);

        // Random request stalls, 5-cycle memory, random consumer, address wrap.
        rr_mode    = 1;
        resp_delay = 5;
        pr_mode    = 2;
        start_frame(32'hFFFF_FFFA, 5, 3);
        wait_done(2000);
        check_frame("wrap5x3", 32'hFFFF_FFFA, 5, 3);
        rr_mode    = 0;
        resp_delay = 1;
        pr_mode    = 1;

        // Zero-width frame: no requests, one busy cycle, then done.
        start_frame(32'h3000, 0, 5);
        @(posedge clock);
        #1;
        check("w0_busy_low", busy, 0);
        check("w0_done_high", done, 1);
        @(posedge clock);
        #1;
        check("w0_done_pulse_end", done, 0);
        check("w0_req_count", req_log.size(), 0);

        // Reset with three requests in flight; their late responses must be dropped.
        resp_delay = 20;
        start_frame(32'h4000, 8, 1);
        for (int n = 0; n < 50 && req_log.size() < 3; n++) begin
            @(posedge clock);
            #1;
        end
        check("rst_mid_three_issued", req_log.size(), 3);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_mid_reqvalid", reqValid, 0);
        check("rst_mid_busy", busy, 0);
        reset = 1'b0;
        clear_logs();
        repeat (40) @(posedge clock);
        #1;
        check("rst_mid_stale_resps", resp_cnt, 3);
        check("rst_mid_no_pixels", pv_cnt, 0);
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_pixvalid", pixelValid, 0);
        resp_delay = 1;
        start_frame(32'h0200, 2, 2);
        wait_done(200);
        check_frame("after_rst", 32'h0200, 2, 2);

        // A second start while busy is ignored.
        start_frame(32'h0040, 3, 2);
        @(posedge clock);
        #1;
        start        = 1'b1;
        frameAddress = 32'h0999;
        width        = 12'd7;
        height       = 12'd9;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(300);
        check_frame("restart", 32'h0040, 3, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
